// File: rtl/bkg_pkg.sv
// Shared constants, FSM state type and subtract/clamp helper for the bkg_ram
// background path.
package bkg_pkg;

   localparam int FRAME_W = 27;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 8;

   localparam logic [FRAME_W-1:0] FRAME_MAX = {FRAME_W{1'b1}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_FRAME = 2'd1,
      GAP      = 2'd2
   } bkg_state_e;

   function automatic logic [DATA_W-1:0] sub_clamp(input logic [DATA_W-1:0] data,
                                                    input logic [DATA_W-1:0] bkg);
      logic [DATA_W:0] diff;
      diff = {1'b0, data} - {1'b0, bkg};
      sub_clamp = diff[DATA_W] ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/bkg_sub_if.sv
// Pixel stream in/out plus the bkg_ram side-channel of bkg_sub.
// BKG_SUB_CLAMP_CNT_EN adds the clamp_cnt status field.
interface bkg_sub_if;
   import bkg_pkg::*;

   logic               acq_start;
   logic               in_valid;
   logic               in_sop;
   logic               in_eop;
   logic [DATA_W-1:0]  in_data;
   logic [FRAME_W-1:0] frameID;
   logic [ADDR_W-1:0]  address;
   logic [DATA_W-1:0]  bkg_signal;
   logic               bkg_sub_status;
   logic               out_valid;
   logic               out_sop;
   logic               out_eop;
   logic [DATA_W-1:0]  out_data;
   logic [FRAME_W-1:0] out_frameID;
   logic               frame_err;
`ifdef BKG_SUB_CLAMP_CNT_EN
   logic [15:0]        clamp_cnt;

   modport slave (
      input  acq_start, in_valid, in_sop, in_eop, in_data, bkg_signal, bkg_sub_status,
      output frameID, address, out_valid, out_sop, out_eop, out_data, out_frameID,
             frame_err, clamp_cnt
   );

   modport master (
      output acq_start, in_valid, in_sop, in_eop, in_data, bkg_signal, bkg_sub_status,
      input  frameID, address, out_valid, out_sop, out_eop, out_data, out_frameID,
             frame_err, clamp_cnt
   );
`else
   modport slave (
      input  acq_start, in_valid, in_sop, in_eop, in_data, bkg_signal, bkg_sub_status,
      output frameID, address, out_valid, out_sop, out_eop, out_data, out_frameID,
             frame_err
   );

   modport master (
      output acq_start, in_valid, in_sop, in_eop, in_data, bkg_signal, bkg_sub_status,
      input  frameID, address, out_valid, out_sop, out_eop, out_data, out_frameID,
             frame_err
   );
`endif

endinterface

// File: rtl/bkg_sub_delay.sv
// Fixed-depth register pipeline with asynchronous reset; aligns sample fields
// with the bkg_ram read latency.
module bkg_sub_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk_clk,
   input  logic             rst_reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] pipe_r [DEPTH];

   // Shift register; reset clears every stage so no stale valid survives
   always_ff @(posedge clk_clk or posedge rst_reset) begin
      if (rst_reset) begin
         for (int i = 0; i < DEPTH; i++) pipe_r[i] <= {WIDTH{1'b0}};
      end else begin
         pipe_r[0] <= din;
         for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
      end
   end

   assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/bkg_sub.sv
// Background subtractor: drives bkg_ram frameID/address, aligns raw samples with
// the returned background and emits raw-background clamped at zero.
// Optional BKG_SUB_CLAMP_CNT_EN: per-frame count of clamped samples.
module bkg_sub
   import bkg_pkg::*;
#(
   parameter int N_CH    = 256,
   parameter int RAM_LAT = 2
) (
   input  logic     clk_clk,
   input  logic     rst_reset,
   bkg_sub_if.slave bus
);

   localparam int                 PIPE_W    = 3 + FRAME_W + DATA_W;
   localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(N_CH - 1);
   localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

   bkg_state_e         state_r;
   bkg_state_e         state_nxt_s;
   logic [ADDR_W-1:0]  addr_cnt_r;
   logic [ADDR_W-1:0]  addr_s;
   logic [FRAME_W-1:0] frame_id_r;
   logic               frame_err_r;
   logic               accept_s;
   logic               err_set_s;
   logic [PIPE_W-1:0]  pipe_in_s;
   logic [PIPE_W-1:0]  pipe_out_s;
   logic               d_valid_s;
   logic               d_sop_s;
   logic               d_eop_s;
   logic [FRAME_W-1:0] d_frame_s;
   logic [DATA_W-1:0]  d_data_s;
   logic [DATA_W-1:0]  result_s;
   logic               out_valid_r;
   logic               out_sop_r;
   logic               out_eop_r;
   logic [DATA_W-1:0]  out_data_r;
   logic [FRAME_W-1:0] out_frame_r;

   assign addr_s          = bus.in_sop ? {ADDR_W{1'b0}} : addr_cnt_r;
   assign bus.address     = addr_s;
   assign bus.frameID     = frame_id_r;
   assign bus.frame_err   = frame_err_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_sop     = out_sop_r;
   assign bus.out_eop     = out_eop_r;
   assign bus.out_data    = out_data_r;
   assign bus.out_frameID = out_frame_r;

   // FSM state register
   always_ff @(posedge clk_clk or posedge rst_reset) begin
      if (rst_reset) state_r <= IDLE;
      else           state_r <= state_nxt_s;
   end

   // Next state, sample acceptance and framing-error detection
   always_comb begin
      state_nxt_s = state_r;
      accept_s    = 1'b0;
      err_set_s   = 1'b0;
      if (bus.acq_start) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.in_valid && bus.in_sop) begin
                  accept_s    = 1'b1;
                  state_nxt_s = bus.in_eop ? GAP : IN_FRAME;
               end else begin
                  err_set_s = bus.in_valid;
               end
            end
            IN_FRAME: begin
               accept_s    = bus.in_valid;
               err_set_s   = bus.in_valid & bus.in_sop;
               state_nxt_s = (bus.in_valid && bus.in_eop) ? GAP : IN_FRAME;
            end
            GAP: begin
               state_nxt_s = IDLE;
               err_set_s   = bus.in_valid;
            end
            default: state_nxt_s = IDLE;
         endcase
         // eop must land exactly on the last channel, and the last channel must carry eop
         err_set_s = err_set_s | (accept_s & (bus.in_eop ^ (addr_s == LAST_ADDR)));
      end
   end

   // Channel counter, frame counter and sticky framing error
   always_ff @(posedge clk_clk or posedge rst_reset) begin
      if (rst_reset) begin
         addr_cnt_r  <= {ADDR_W{1'b0}};
         frame_id_r  <= {FRAME_W{1'b0}};
         frame_err_r <= 1'b0;
      end else if (bus.acq_start) begin
         addr_cnt_r  <= {ADDR_W{1'b0}};
         frame_id_r  <= {FRAME_W{1'b0}};
         frame_err_r <= 1'b0;
      end else begin
         if (accept_s) begin
            if (bus.in_eop)                addr_cnt_r <= {ADDR_W{1'b0}};
            else if (addr_s == LAST_ADDR)  addr_cnt_r <= LAST_ADDR;
            else                           addr_cnt_r <= addr_s + ADDR_ONE;
            if (bus.in_eop && frame_id_r != FRAME_MAX) frame_id_r <= frame_id_r + FRAME_ONE;
         end
         if (err_set_s) frame_err_r <= 1'b1;
      end
   end

   assign pipe_in_s = {accept_s, accept_s & bus.in_sop, accept_s & bus.in_eop,
                       frame_id_r, bus.in_data};

   bkg_sub_delay #(
      .WIDTH (PIPE_W),
      .DEPTH (RAM_LAT)
   ) u_delay (
      .clk_clk   (clk_clk),
      .rst_reset (rst_reset),
      .din       (pipe_in_s),
      .dout      (pipe_out_s)
   );

   assign {d_valid_s, d_sop_s, d_eop_s, d_frame_s, d_data_s} = pipe_out_s;
   assign result_s = bus.bkg_sub_status ? sub_clamp(d_data_s, bus.bkg_signal) : d_data_s;

   // Registered output stage
   always_ff @(posedge clk_clk or posedge rst_reset) begin
      if (rst_reset) begin
         out_valid_r <= 1'b0;
         out_sop_r   <= 1'b0;
         out_eop_r   <= 1'b0;
         out_data_r  <= {DATA_W{1'b0}};
         out_frame_r <= {FRAME_W{1'b0}};
      end else begin
         out_valid_r <= d_valid_s;
         out_sop_r   <= d_sop_s;
         out_eop_r   <= d_eop_s;
         if (d_valid_s) begin
            out_data_r  <= result_s;
            out_frame_r <= d_frame_s;
         end
      end
   end

`ifdef BKG_SUB_CLAMP_CNT_EN
   logic        clamp_hit_s;
   logic [15:0] run_base_s;
   logic [15:0] run_nxt_s;
   logic [15:0] run_cnt_r;
   logic [15:0] clamp_cnt_r;

   assign clamp_hit_s   = bus.bkg_sub_status & (d_data_s < bus.bkg_signal);
   assign bus.clamp_cnt = clamp_cnt_r;

   // Saturating running count, restarted by sop
   always_comb begin
      run_base_s = d_sop_s ? 16'd0 : run_cnt_r;
      if (clamp_hit_s && run_base_s != 16'hFFFF) run_nxt_s = run_base_s + 16'd1;
      else                                       run_nxt_s = run_base_s;
   end

   // Running count and value latched at end of frame
   always_ff @(posedge clk_clk or posedge rst_reset) begin
      if (rst_reset) begin
         run_cnt_r   <= 16'd0;
         clamp_cnt_r <= 16'd0;
      end else if (d_valid_s) begin
         if (d_eop_s) begin
            clamp_cnt_r <= run_nxt_s;
            run_cnt_r   <= 16'd0;
         end else begin
            run_cnt_r   <= run_nxt_s;
         end
      end
   end
`endif

endmodule

// File: tb/tb_bkg_sub.sv
// Randomised bench for bkg_sub with an emulated bkg_ram (latency 2, output mode
// once frameID exceeds TOTAL_FRAME) and a frame-level reference model.
module tb_bkg_sub;

   localparam int N_CH        = 4;
   localparam int RAM_LAT     = 2;
   localparam int TOTAL_FRAME = 4;
   localparam int LAT         = RAM_LAT + 1;
   localparam int FID_MAX     = (1 << 27) - 1;

   typedef struct {
      int due;
      bit sop;
      bit eop;
      bit clamp;
      int fid;
      int data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bkg_sub_if bus();

   bkg_sub #(.N_CH(N_CH), .RAM_LAT(RAM_LAT)) dut (
      .clk_clk   (clk),
      .rst_reset (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   // Emulated bkg_ram: background table per channel, status from frame number
   logic [15:0] tab [N_CH];
   logic [16:0] ram_p1 = 17'd0;
   logic [16:0] ram_p2 = 17'd0;
   always @(posedge clk) begin
      ram_p1 <= {(int'(bus.frameID) > TOTAL_FRAME), tab[bus.address[1:0]]};
      ram_p2 <= ram_p1;
   end
   assign bus.bkg_signal     = ram_p2[15:0];
   assign bus.bkg_sub_status = ram_p2[16];

   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;
   exp_t q[$];
   int   m_fid, m_addr, m_run, m_clamp;
   bit   m_err, m_in_frame, m_gap;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      q.delete();
      m_fid = 0; m_addr = 0; m_err = 1'b0; m_in_frame = 1'b0; m_gap = 1'b0;
      m_run = 0; m_clamp = 0;
   endtask

   task automatic check_outputs();
      exp_t e;
      chk("frameID", bus.frameID, m_fid);
      chk("frame_err", bus.frame_err, m_err);
      if (q.size() != 0 && q[0].due == cyc) begin
         e = q.pop_front();
         chk("out_valid", bus.out_valid, 1);
         chk("out_sop", bus.out_sop, e.sop);
         chk("out_eop", bus.out_eop, e.eop);
         chk("out_data", bus.out_data, e.data);
         chk("out_frameID", bus.out_frameID, e.fid);
         if (e.sop)             m_run = e.clamp;
         else if (m_run < 65535) m_run += e.clamp;
         if (e.eop) begin
            m_clamp = m_run;
            m_run   = 0;
         end
      end else begin
         chk("out_valid", bus.out_valid, 0);
      end
`ifdef BKG_SUB_CLAMP_CNT_EN
      chk("clamp_cnt", bus.clamp_cnt, m_clamp);
`endif
   endtask

   task automatic model_in(input bit v, input bit sop, input bit eop, input int d, input bit acq);
      int   a;
      bit   acc, st;
      exp_t e;
      a = sop ? 0 : m_addr;
      chk("address", bus.address, a);
      if (acq) begin
         m_fid = 0; m_err = 1'b0; m_in_frame = 1'b0; m_gap = 1'b0; m_addr = 0;
         return;
      end
      acc = 1'b0;
      if (m_gap) begin
         if (v) m_err = 1'b1;
         m_gap = 1'b0;
      end else if (!m_in_frame) begin
         if (v && sop) acc = 1'b1;
         else if (v)   m_err = 1'b1;
      end else if (v) begin
         acc = 1'b1;
         if (sop) m_err = 1'b1;
      end
      if (!acc) return;
      st      = (m_fid > TOTAL_FRAME);
      e.due   = cyc + LAT;
      e.sop   = sop;
      e.eop   = eop;
      e.fid   = m_fid;
      e.clamp = st && (d < int'(tab[a]));
      e.data  = !st ? d : (d > int'(tab[a]) ? d - int'(tab[a]) : 0);
      q.push_back(e);
      if (eop) begin
         if (a != N_CH - 1) m_err = 1'b1;
         m_in_frame = 1'b0;
         m_gap      = 1'b1;
         m_addr     = 0;
         if (m_fid < FID_MAX) m_fid++;
      end else begin
         m_in_frame = 1'b1;
         if (a == N_CH - 1) begin
            m_err  = 1'b1;
            m_addr = N_CH - 1;
         end else begin
            m_addr = a + 1;
         end
      end
   endtask

   // One clock cycle: drive, check at the falling edge, advance the model
   task automatic step(input bit v, input bit sop, input bit eop, input int d, input bit acq);
      bus.in_valid  = v;
      bus.in_sop    = sop;
      bus.in_eop    = eop;
      bus.in_data   = d[15:0];
      bus.acq_start = acq;
      @(negedge clk);
      check_outputs();
      model_in(v, sop, eop, d, acq);
      @(posedge clk);
      #1;
      cyc++;
      bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.acq_start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0; bus.acq_start = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_sop", bus.out_sop, 0);
      chk("rst_out_eop", bus.out_eop, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_frameID", bus.out_frameID, 0);
      chk("rst_frameID", bus.frameID, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_address", bus.address, 0);
`ifdef BKG_SUB_CLAMP_CNT_EN
      chk("rst_clamp_cnt", bus.clamp_cnt, 0);
`endif
      model_clear();
      @(posedge clk);
      #1;
      cyc++;
      rst = 1'b0;
   endtask

   task automatic frame4(input int d0, input int d1, input int d2, input int d3);
      step(1, 1, 0, d0, 0);
      step(1, 0, 0, d1, 0);
      step(1, 0, 0, d2, 0);
      step(1, 0, 1, d3, 0);
      step(0, 0, 0, 0, 0);
   endtask

   initial begin
      int len;
      bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
      bus.in_data = 16'd0; bus.acq_start = 1'b0;
      for (int a = 0; a < N_CH; a++) tab[a] = 16'd100;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Six frames of 100: five pass through, the sixth meets background 100
      step(0, 0, 0, 0, 1);
      for (int f = 0; f < 6; f++) frame4(100, 100, 100, 100);
      // Subtraction and clamping in output mode
      frame4(130, 40, 130, 40);
      repeat (LAT) step(0, 0, 0, 0, 0);
`ifdef BKG_SUB_CLAMP_CNT_EN
      chk("clamp_two", bus.clamp_cnt, 2);
`endif

      // Short frame: eop on the third sample
      step(1, 1, 0, 7, 0);
      step(1, 0, 0, 8, 0);
      step(1, 0, 1, 9, 0);
      chk("short_frame_err", bus.frame_err, 1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      chk("acq_clr_err", bus.frame_err, 0);
      chk("acq_clr_fid", bus.frameID, 0);

      // Sample arriving in the gap cycle
      step(1, 1, 0, 1, 0);
      step(1, 0, 0, 2, 0);
      step(1, 0, 0, 3, 0);
      step(1, 0, 1, 4, 0);
      step(1, 0, 0, 5, 0);
      chk("gap_err", bus.frame_err, 1);
      step(0, 0, 0, 0, 1);

      // Reset after two samples, then a clean frame from channel 0
      step(1, 1, 0, 11, 0);
      step(1, 0, 0, 12, 0);
      do_reset();
      frame4(21, 22, 23, 24);

      // acq_start mid-frame drops the tail until the next sop
      step(1, 1, 0, 31, 0);
      step(1, 0, 0, 32, 0);
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 33, 0);
      step(1, 0, 1, 34, 0);
      step(0, 0, 0, 0, 0);
      frame4(41, 42, 43, 44);

      // Randomised frames, lengths and gap intrusions
      step(0, 0, 0, 0, 1);
      for (int f = 0; f < 40; f++) begin
         for (int a = 0; a < N_CH; a++) tab[a] = 16'($urandom_range(0, 300));
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 6) : N_CH;
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 5) == 0) step(0, 0, 0, 0, 0);
            step(1, i == 0, i == len - 1, $urandom_range(0, 400), 0);
         end
         if ($urandom_range(0, 9) == 0) step(1, 0, 0, $urandom_range(0, 400), 0);
         step(0, 0, 0, 0, 0);
         if ($urandom_range(0, 3) == 0) step(0, 0, 0, 0, 0);
      end
      repeat (LAT + 2) step(0, 0, 0, 0, 0);
      chk("drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
